input_control_unit: RTL

INPUT_CONTROL_UNIT -- requirements
Module: input_control_unit

---
 rtl/input_control_unit_pkg.sv | 16 +
 rtl/input_control_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/input_control_unit_pkg.sv
// Shared NIC input-side parameters; DATA_FLITS / BUFFER_DEPTH come from the build.
// Optional feature macro used by the top: NIC_INPUT_OVERFLOW_CHECK_EN.
`ifndef DATA_FLITS
`define DATA_FLITS 4
`endif
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 1
`endif

package input_control_unit_pkg;
    localparam int DATA_FLITS   = `DATA_FLITS;
    localparam int BUFFER_DEPTH = `BUFFER_DEPTH;
    localparam int SEL_W        = 3;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DATA_FLITS);
endpackage

// File: rtl/input_control_unit.sv
// NIC input control: collects a header plus data flits, hands them to the node.
// Define NIC_INPUT_OVERFLOW_CHECK_EN to build the sticky overflow flag.
module input_control_unit
    import input_control_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flit_valid_din,
    input  logic             zero_credits_din,
    input  logic             done_strobe_din,
    output logic             capture_en_dout,
    output logic [SEL_W-1:0] capture_sel_dout,
    output logic             start_strobe_dout,
    output logic             credit_out_dout,
    output logic             node_busy_dout,
    output logic             overflow_error_dout
);

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_CAPTURE = 2'd1,
        RX_FULL    = 2'd2
    } rx_state_e;

    typedef enum logic {
        CORE_IDLE = 1'b0,
        CORE_BUSY = 1'b1
    } core_state_e;

    rx_state_e        rx_q, rx_d;
    core_state_e      core_q, core_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             cap_en;
    logic [SEL_W-1:0] cap_sel;
    logic             transfer;

    // Transfer looks only at registered core state, so a done pulse
    // coincident with a full buffer starts the node one cycle later.
    assign transfer = (rx_q == RX_FULL) && (core_q == CORE_IDLE)
                      && !zero_credits_din;

    always_comb begin
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;
        cap_sel = '0;
        unique case (rx_q)
            RX_IDLE: begin
                if (flit_valid_din) begin
                    cap_en = 1'b1;
                    cnt_d  = SEL_W'(1);
                    rx_d   = RX_CAPTURE;
                end
            end
            RX_CAPTURE: begin
                if (flit_valid_din) begin
                    cap_en  = 1'b1;
                    cap_sel = cnt_q;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        rx_d  = RX_FULL;
                    end else begin
                        cnt_d = cnt_q + SEL_W'(1);
                    end
                end
            end
            RX_FULL: begin
                if (transfer) begin
                    rx_d = RX_IDLE;
                end
            end
            default: begin
                rx_d  = RX_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        core_d = core_q;
        unique case (core_q)
            CORE_IDLE: if (transfer) core_d = CORE_BUSY;
            CORE_BUSY: if (done_strobe_din) core_d = CORE_IDLE;
            default:   core_d = CORE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q   <= RX_IDLE;
            core_q <= CORE_IDLE;
            cnt_q  <= '0;
        end else begin
            rx_q   <= rx_d;
            core_q <= core_d;
            cnt_q  <= cnt_d;
        end
    end

    assign capture_en_dout   = cap_en && !reset;
    assign capture_sel_dout  = reset ? '0 : cap_sel;
    assign start_strobe_dout = transfer && !reset;
    assign credit_out_dout   = transfer && !reset;
    assign node_busy_dout    = (core_q == CORE_BUSY) && !reset;

`ifdef NIC_INPUT_OVERFLOW_CHECK_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if ((rx_q == RX_FULL) && flit_valid_din) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow_error_dout = ovf_q;
`else
    assign overflow_error_dout = 1'b0;
`endif

endmodule
